// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the CPU fetch front end: PC select codes and the
// latency/depth limits of the fetch queue.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'd0,
    PC_SEL_JMP    = 2'd1,
    PC_SEL_BRANCH = 2'd2,
    PC_SEL_HOLD   = 2'd3
  } pc_sel_e;

  localparam int FQ_MIN_RD_LATENCY = 1;
  localparam int FQ_MAX_RD_LATENCY = 4;

  // One slot per outstanding read plus one for the head held under a stall.
  function automatic int fq_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Show-ahead FIFO with synchronous flush; dout always presents the oldest entry.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues code-memory reads against a fixed read latency and
// buffers returned instructions, tagged with their PC-advance count.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int INSTR_WIDTH     = 64,
  parameter  int CODE_RD_LATENCY = 1,
  parameter  int CNT_WIDTH       = 6,
  localparam int QDEPTH          = fq_depth(CODE_RD_LATENCY)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branch_mispredict,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   next_rdy,
  output logic                   inst_rd_en,
  output logic                   PC_en,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [CNT_WIDTH-1:0]   ocount,
  output logic                   vld
);

  localparam int QCNT_W = $clog2(QDEPTH + 1);
  localparam int OCC_W  = QCNT_W + 1;
  localparam int ENT_W  = INSTR_WIDTH + CNT_WIDTH;

  if (CODE_RD_LATENCY < FQ_MIN_RD_LATENCY || CODE_RD_LATENCY > FQ_MAX_RD_LATENCY) begin : g_bad_latency
    $error("fetch_queue: CODE_RD_LATENCY out of range");
  end

  logic [CODE_RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [CNT_WIDTH-1:0]       tag_cnt_q [CODE_RD_LATENCY];
  logic [CNT_WIDTH-1:0]       tag_cnt_d [CODE_RD_LATENCY];
  logic [CNT_WIDTH-1:0]       fcnt_q, fcnt_d;
  logic [OCC_W-1:0]           inflight;
  logic [OCC_W-1:0]           occ;
  logic [QCNT_W-1:0]          qcount;
  logic [ENT_W-1:0]           head_ent;
  logic                       issue;
  logic                       capture;
  logic                       pop;
  logic                       q_vld;

  always_comb begin
    pop = q_vld & next_rdy & ~branch_mispredict;

    inflight = '0;
    for (int i = 0; i < CODE_RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(tag_vld_q[i]);
    end

    // Every read in flight owns a queue slot, so the queue cannot overflow.
    occ     = inflight + OCC_W'(qcount) - OCC_W'(pop);
    issue   = ~branch_mispredict & (occ < OCC_W'(QDEPTH));
    capture = tag_vld_q[CODE_RD_LATENCY-1] & ~branch_mispredict;
    fcnt_d  = fcnt_q + CNT_WIDTH'(issue);

    // Issue stage -> in-flight stage 0; each stage advances one cycle.
    tag_vld_d    = '0;
    tag_cnt_d    = tag_cnt_q;
    tag_vld_d[0] = issue;
    tag_cnt_d[0] = fcnt_q;
    for (int i = 1; i < CODE_RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1] & ~branch_mispredict;
      tag_cnt_d[i] = tag_cnt_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      fcnt_q    <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_cnt_q <= tag_cnt_d;
  end

  // Last in-flight stage -> queue: read data joins its issue-time tag.
  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (pop),
    .flush (branch_mispredict),
    .din   ({instr_in, tag_cnt_q[CODE_RD_LATENCY-1]}),
    .dout  (head_ent),
    .count (qcount)
  );

  assign q_vld      = (qcount != '0);
  assign vld        = q_vld;
  assign inst_rd_en = issue & rst_n;
  assign PC_en      = issue & rst_n;
  assign instr_out  = q_vld ? head_ent[ENT_W-1:CNT_WIDTH] : '0;
  assign ocount     = q_vld ? (fcnt_q - head_ent[CNT_WIDTH-1:0]) : '0;

endmodule
